psum_accum: RTL and testbench
=============================

# psum_accum

Read-modify-write engine that drives the read and write ports of the partial-sum memory (40-bit × 64K). It accepts a stream of (address, contribution) updates from the PE array, adds each contribution to the stored partial sum, and writes the result back. On the final pass of an output pixel it also emits the finished sum downstream. Hazard forwarding lets back-to-back updates hit the same address at full rate.

## Interface
- DW, 40, partial-sum width (signed two's complement)
- AW, 16, psum memory address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  update request valid
- in_ready  out  1  update request accepted when in_valid & in_ready
- in_addr  in  AW  target address
- in_data  in  DW  signed contribution
- in_first  in  1  first pass: ignore stored value, result = in_data
- in_last  in  1  final pass: also emit result downstream
- re  out  1  memory read enable (combinational = in_valid & in_ready)
- ra  out  AW  memory read address (= in_addr)
- rd  in  DW  memory read data, valid the cycle after re
- we  out  1  memory write enable (registered)
- wa  out  AW  memory write address (registered)
- wd  out  DW  memory write data (registered)
- out_valid  out  1  finished sum available
- out_ready  in  1  downstream accepts
- out_addr  out  AW  address of finished sum
- out_data  out  DW  finished sum

## Operation
- Pipeline stages:
  - S0: accept, issue read.
  - S1: rd valid, compute sum.
  - S2: we/wa/wd driven, memory written at end of S2.
  - S3: one-deep history of the last write.
- S1 sum:
  - in_first=1: sum = in_data.
  - Otherwise sum = base + in_data, where base is selected by priority:
    - S2 result, if S2 valid and S2 addr == S1 addr;
    - else S3 result, if S3 valid and S3 addr == S1 addr;
    - else rd.
- S3 forwarding covers the same-edge read/write case: memory returns the old value on a read-during-write to the same address.
- S1 never stalls. Every accepted update produces exactly one write.
- Output path:
  - An S1 op with last=1 pushes (addr, sum) into a 2-entry output FIFO in the same cycle S2 loads.
  - Credit rule: in_ready = (fifo_count + (s1_valid & s1_last)) < 2.
  - The rule is conservative: it also throttles non-last updates.
- Arithmetic is DW-bit signed. Wrap or saturate per Configuration.
- Reset values:
  - in_ready = 1; we = 0; wa = 0; wd = 0.
  - out_valid = 0; out_addr = 0; out_data = 0.
  - All stage valids = 0; FIFO empty.
- Reset mid-operation: in-flight updates are dropped with no write. Memory contents are not cleared.

## Timing
- Update accepted at edge E0: re high before E0; rd valid E0..E1; S2 loads at E1; we high E1..E2; memory updated at E2.
- Throughput: 1 update/cycle while credits allow.
- Latency: accept to out_valid = 2 edges (FIFO loads at E1, visible after E1) when the FIFO is empty.
- Same address at E0, E1, E2 sums correctly via S2 and S3 forwarding.
- FIFO: push and pop in the same cycle keep the count. Pop occurs on out_valid & out_ready. out_data is stable while out_valid & !out_ready.

## Configuration
- PSUM_ACC_SAT_EN defined:
  - Signed overflow clamps to 2^(DW-1)-1.
  - Signed underflow clamps to -2^(DW-1).
  - Applies to both the written value and the emitted value.
- PSUM_ACC_SAT_EN undefined: plain two's-complement wrap, with no extra logic.

## Structure
- Shared package holds:
  - DW/AW defaults;
  - a psum_op typedef (valid, addr, data, first, last);
  - a psum_res typedef (valid, addr, data);
  - PSUM_MAX/PSUM_MIN constants.
- One sub-module: psum_out_fifo, a 2-entry DW+AW-bit FIFO with count output.

## Test plan
- Single update with first=1, last=1, addr 0x0010, data 5: write 5 to 0x0010; out_data=5 two edges after accept.
- Address 0x0020 preloaded with 100; updates +1, +2, +3 on consecutive cycles, last on the third: writes 101, 103, 106; out_data=106.
- Alternating addresses A, B, A, B with first on the first pass of each and contribution 1 each: final A=2, B=2. Exercises the S3 forward path.
- out_ready held low with three last updates streamed: in_ready drops after the second; no data lost; releasing out_ready yields three outputs in order.
- With PSUM_ACC_SAT_EN: stored 2^39-1 plus 1 gives wd=2^39-1. Without it: wd=-2^39.
- Reset asserted while we is high: we=0 immediately, out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// Shared types, widths and the accumulate helper for the partial-sum RMW engine.
// Optional feature macro: PSUM_ACC_SAT_EN (saturating add instead of wrap).
package psum_accum_pkg;

  localparam int DW = 40;
  localparam int AW = 16;

  localparam logic [DW-1:0] PSUM_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] PSUM_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } psum_op;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } psum_res;

  function automatic logic [DW-1:0] psum_add(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
`ifdef PSUM_ACC_SAT_EN
    logic [DW-1:0] s;
    s = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    if ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1])) begin
      s = a[DW-1] ? PSUM_MIN : PSUM_MAX;
    end
    return s;
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Bundle of the update stream, psum memory port and finished-sum stream.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface psum_accum_if;
  import psum_accum_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_first;
  logic          in_last;

  logic          re;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  modport master (
    input  in_valid, in_addr, in_data, in_first, in_last, rd, out_ready,
    output in_ready, re, ra, we, wa, wd, out_valid, out_addr, out_data
  );

  modport slave (
    output in_valid, in_addr, in_data, in_first, in_last, rd, out_ready,
    input  in_ready, re, ra, we, wa, wd, out_valid, out_addr, out_data
  );

endinterface

// File: rtl/psum_out_fifo.sv
// Two-entry FIFO holding finished (addr, sum) pairs; count feeds the input credit check.
module psum_out_fifo #(
  parameter int W = 56
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/psum_accum.sv
// Partial-sum read-modify-write engine with S2/S3 hazard forwarding and a 2-deep result FIFO.
// Build with PSUM_ACC_SAT_EN defined for saturating accumulation (see psum_accum_pkg).
module psum_accum
  import psum_accum_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  psum_accum_if.master  bus
);

  psum_op        s1_q, s1_d;
  psum_res       s2_q, s2_d;
  psum_res       s3_q;
  logic          accept;
  logic [DW-1:0] base;
  logic [DW-1:0] sum;
  logic          fifo_push;
  logic [1:0]    fifo_count;
  logic          fifo_valid;
  logic [AW+DW-1:0] fifo_data;

  // Conservative credit: reserve a FIFO slot for an S1 op that will push next edge.
  assign bus.in_ready = ({1'b0, fifo_count} + {2'b00, (s1_q.valid & s1_q.last)}) < 3'd2;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.re       = accept;
  assign bus.ra       = bus.in_addr;

  always_comb begin
    s1_d       = '0;
    s1_d.valid = accept;
    s1_d.addr  = bus.in_addr;
    s1_d.data  = bus.in_data;
    s1_d.first = bus.in_first;
    s1_d.last  = bus.in_last;
  end

  // S3 covers a write landing on the same edge the read was sampled (memory returns old data).
  always_comb begin
    base = bus.rd;
    if (s2_q.valid && (s2_q.addr == s1_q.addr)) begin
      base = s2_q.data;
    end else if (s3_q.valid && (s3_q.addr == s1_q.addr)) begin
      base = s3_q.data;
    end
    sum = s1_q.first ? s1_q.data : psum_add(base, s1_q.data);
  end

  always_comb begin
    s2_d       = s2_q;
    s2_d.valid = s1_q.valid;
    if (s1_q.valid) begin
      s2_d.addr = s1_q.addr;
      s2_d.data = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s2_q;
    end
  end

  assign bus.we = s2_q.valid;
  assign bus.wa = s2_q.addr;
  assign bus.wd = s2_q.data;

  assign fifo_push = s1_q.valid & s1_q.last;

  psum_out_fifo #(
    .W(AW + DW)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({s1_q.addr, sum}),
    .pop_i       (bus.out_ready),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .count_o     (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_addr  = fifo_data[AW+DW-1:DW];
  assign bus.out_data  = fifo_data[DW-1:0];

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: behavioural psum memory, reference model and write/output scoreboards.
module tb_psum_accum;
  import psum_accum_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psum_accum_if bus ();

  psum_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural memory: read-during-write returns the old value.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (bus.re) bus.rd <= mem[bus.ra];
    if (bus.we) mem[bus.wa] <= bus.wd;
  end

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [AW+DW-1:0] exp_wr_q [$];
  logic [AW+DW-1:0] exp_out_q[$];
  logic [AW+DW-1:0] last_out;

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] wide;
    wide = {a[DW-1], a} + {b[DW-1], b};
`ifdef PSUM_ACC_SAT_EN
    if (wide[DW] != wide[DW-1]) return wide[DW] ? PSUM_MIN : PSUM_MAX;
`endif
    return wide[DW-1:0];
  endfunction

  // Scoreboard: writes and finished sums compared in order against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.we === 1'b1) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected got wa=%h wd=%h, none expected", bus.wa, bus.wd);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_wr_q.pop_front();
          if ({bus.wa, bus.wd} !== e) begin
            failures++;
            $display("FAIL write got wa=%h wd=%h expected wa=%h wd=%h", bus.wa, bus.wd, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        n_out++;
        last_out = {bus.out_addr, bus.out_data};
        if (exp_out_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected got addr=%h data=%h, none expected", bus.out_addr, bus.out_data);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_out_q.pop_front();
          if ({bus.out_addr, bus.out_data} !== e) begin
            failures++;
            $display("FAIL out got addr=%h data=%h expected addr=%h data=%h", bus.out_addr, bus.out_data, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic send_update(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f, input logic l);
    int waited;
    logic [DW-1:0] r;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required 1 within 50 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    r = f ? d : model_add(ref_mem[a], d);
    ref_mem[a] = r;
    exp_wr_q.push_back({a, r});
    if (l) exp_out_q.push_back({a, r});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.we, bus.out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got in_ready,we,out_valid=%b required 100", {bus.in_ready, bus.we, bus.out_valid});
    end
    checks++;
    if (bus.wa !== '0 || bus.wd !== '0 || bus.out_addr !== '0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got wa=%h wd=%h out_addr=%h out_data=%h required all 0", bus.wa, bus.wd, bus.out_addr, bus.out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_update(16'h0010, 40'd5, 1'b1, 1'b1);
    idle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_out got out_valid=%b required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.we, bus.wa, bus.wd} !== {1'b1, 16'h0010, 40'd5}) begin
      failures++;
      $display("FAIL single_write got we=%b wa=%h wd=%0d required we=1 wa=0010 wd=5", bus.we, bus.wa, bus.wd);
    end
    checks++;
    if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 16'h0010, 40'd5}) begin
      failures++;
      $display("FAIL single_out got valid=%b addr=%h data=%0d required valid=1 addr=0010 data=5", bus.out_valid, bus.out_addr, bus.out_data);
    end
    drain();
    checks++;
    if (mem[16'h0010] !== 40'd5) begin
      failures++;
      $display("FAIL single_mem got %0d required 5", mem[16'h0010]);
    end
  endtask

  task automatic test_back_to_back();
    preload(16'h0020, 40'd100);
    send_update(16'h0020, 40'd1, 1'b0, 1'b0);
    send_update(16'h0020, 40'd2, 1'b0, 1'b0);
    send_update(16'h0020, 40'd3, 1'b0, 1'b1);
    drain();
    checks++;
    if (mem[16'h0020] !== 40'd106) begin
      failures++;
      $display("FAIL b2b_mem got %0d required 106", mem[16'h0020]);
    end
    checks++;
    if (last_out !== {16'h0020, 40'd106}) begin
      failures++;
      $display("FAIL b2b_out got %h required %h", last_out, {16'h0020, 40'd106});
    end
  endtask

  task automatic test_alternate();
    send_update(16'h0040, 40'd1, 1'b1, 1'b0);
    send_update(16'h0041, 40'd1, 1'b1, 1'b0);
    send_update(16'h0040, 40'd1, 1'b0, 1'b0);
    send_update(16'h0041, 40'd1, 1'b0, 1'b0);
    drain();
    checks++;
    if (mem[16'h0040] !== 40'd2 || mem[16'h0041] !== 40'd2) begin
      failures++;
      $display("FAIL alternate_mem got A=%0d B=%0d required 2 and 2", mem[16'h0040], mem[16'h0041]);
    end
  endtask

  task automatic test_backpressure();
    int base_out;
    base_out      = n_out;
    bus.out_ready = 1'b0;
    send_update(16'h0050, 40'd11, 1'b1, 1'b1);
    send_update(16'h0051, 40'd22, 1'b1, 1'b1);
    idle();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit got in_ready=%b required 0", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_addr, bus.out_data} !== {1'b0, 1'b1, 16'h0050, 40'd11}) begin
      failures++;
      $display("FAIL bp_hold got in_ready=%b valid=%b addr=%h data=%0d required 0 1 0050 11", bus.in_ready, bus.out_valid, bus.out_addr, bus.out_data);
    end
    bus.out_ready = 1'b1;
    send_update(16'h0052, 40'd33, 1'b1, 1'b1);
    drain();
    checks++;
    if (n_out - base_out !== 3) begin
      failures++;
      $display("FAIL bp_count got %0d outputs required 3", n_out - base_out);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] exp_hi;
    logic [DW-1:0] exp_lo;
`ifdef PSUM_ACC_SAT_EN
    exp_hi = PSUM_MAX;
    exp_lo = PSUM_MIN;
`else
    exp_hi = PSUM_MIN;
    exp_lo = PSUM_MAX;
`endif
    preload(16'h0030, PSUM_MAX);
    send_update(16'h0030, 40'd1, 1'b0, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (bus.wd !== exp_hi) begin
      failures++;
      $display("FAIL sat_overflow got wd=%h required %h", bus.wd, exp_hi);
    end
    drain();
    preload(16'h0031, PSUM_MIN);
    send_update(16'h0031, {DW{1'b1}}, 1'b0, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (bus.wd !== exp_lo) begin
      failures++;
      $display("FAIL sat_underflow got wd=%h required %h", bus.wd, exp_lo);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    preload(16'h0060, 40'd9);
    send_update(16'h0060, 40'd7, 1'b1, 1'b1);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.we, bus.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid got we,out_valid=%b required 00", {bus.we, bus.out_valid});
    end
    exp_wr_q.delete();
    exp_out_q.delete();
    ref_mem[16'h0060] = 40'd9;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready got in_ready=%b required 1", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem[16'h0060] !== 40'd9) begin
      failures++;
      $display("FAIL reset_mid_mem got %0d required 9 (write dropped)", mem[16'h0060]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rnd;
    logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      rnd = {$urandom, $urandom};
      a   = 16'h0070 + 16'($urandom_range(0, 3));
      send_update(a, rnd[DW-1:0], ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[16'h0070 + 16'(k)] !== ref_mem[16'h0070 + 16'(k)]) begin
        failures++;
        $display("FAIL random_mem addr %0d got %h required %h", k, mem[16'h0070 + 16'(k)], ref_mem[16'h0070 + 16'(k)]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    last_out = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_alternate();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_wr_q.size() != 0 || exp_out_q.size() != 0) begin
      failures++;
      $display("FAIL drain_left got %0d writes %0d outputs pending required 0", exp_wr_q.size(), exp_out_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
